// File: rtl/encoded_memory_n.sv
// Encoded scratch memory: stores {sign, |data - mask[addr]|} per entry, with init/clear sweeps.
// Define ENCMEM_DECODE_EN to return the reconstructed word instead of the raw magnitude.
`timescale 1ns/1ps
module encoded_memory_n #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_hit,
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_CLEAR} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   ptr;
  logic [DEPTH-1:0]    valid;
  logic [DATA_W:0]     mem [DEPTH];
  logic                sweep, accept, wr_acc, rd_acc;
  logic [DATA_W-1:0]   mask_p0;
  logic [DATA_W:0]     rd_entry_p0, wr_entry_p0;

  function automatic logic [DATA_W-1:0] mask_of(input logic [ADDR_W-1:0] a);
    logic [2:0] sel;
    logic [7:0] b;
    sel = 3'(a);
    case (sel)
      3'd0:    b = 8'h00;
      3'd1:    b = 8'h55;
      3'd2:    b = 8'hAA;
      3'd3:    b = 8'h33;
      3'd4:    b = 8'hCC;
      3'd5:    b = 8'h0F;
      3'd6:    b = 8'hF0;
      default: b = 8'hFF;
    endcase
    return {(DATA_W/8){b}};
  endfunction

  // Sign/magnitude of (d - m); the magnitude always fits DATA_W bits.
  function automatic logic [DATA_W:0] encode(input logic [DATA_W-1:0] d,
                                             input logic [DATA_W-1:0] m);
    logic signed [DATA_W:0] diff;
    logic signed [DATA_W:0] neg;
    diff = $signed({1'b0, d}) - $signed({1'b0, m});
    neg  = -diff;
    if (diff < 0) return {1'b1, neg[DATA_W-1:0]};
    else          return {1'b0, diff[DATA_W-1:0]};
  endfunction

`ifdef ENCMEM_DECODE_EN
  function automatic logic [DATA_W-1:0] decode(input logic [DATA_W:0] e,
                                               input logic [DATA_W-1:0] m);
    return e[DATA_W] ? m - e[DATA_W-1:0] : m + e[DATA_W-1:0];
  endfunction
`endif

  assign sweep       = (state != S_IDLE);
  assign busy        = sweep;
  assign req_ready   = (state == S_IDLE) && !(rsp_valid && !rsp_ready);
  assign accept      = req_valid && req_ready;
  assign wr_acc      = accept && !req_mode;
  assign rd_acc      = accept && req_mode;
  assign mask_p0     = mask_of(req_addr);
  assign rd_entry_p0 = mem[req_addr];
  assign wr_entry_p0 = encode(req_data, mask_p0);

  always_comb begin
    state_n = state;
    case (state)
      S_INIT, S_CLEAR: if (ptr == ADDR_W'(DEPTH-1)) state_n = S_IDLE;
      S_IDLE:          if (clear) state_n = S_CLEAR;
      default:         state_n = S_INIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_INIT;
      ptr   <= '0;
    end else begin
      state <= state_n;
      if (sweep) ptr <= ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid <= '0;
    end else if (sweep) begin
      if (ptr == '0) valid <= '0;
    end else if (wr_acc) begin
      valid[req_addr] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (sweep)       mem[ptr]      <= '0;
    else if (wr_acc) mem[req_addr] <= wr_entry_p0;
  end

  // Response stage: loads on read acceptance, holds until consumed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_hit   <= 1'b0;
    end else if (rd_acc) begin
      rsp_valid <= 1'b1;
      rsp_hit   <= valid[req_addr];
`ifdef ENCMEM_DECODE_EN
      rsp_data  <= decode(rd_entry_p0, mask_p0);
`else
      rsp_data  <= rd_entry_p0[DATA_W-1:0];
`endif
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifndef ENCMEM_DECODE_EN
  logic unused_sign;
  assign unused_sign = rd_entry_p0[DATA_W];
`endif

endmodule
